// File: rtl/servo_pkg.sv
// servo_pkg: shared sweep state encoding, speed-to-step lookup and counter width helper.
package servo_pkg;
    typedef enum logic [1:0] {UP, DOWN, PAUSE, DWELL} state_t;
    function automatic int cnt_w(input int period);
        return (period > 1) ? $clog2(period) : 1;
    endfunction
    function automatic logic [3:0] speed_step(input logic [1:0] code);
        return 4'd1 << code;
    endfunction
endpackage

// File: rtl/servo_sweep_pwm_if.sv
// servo_sweep_pwm_if: control inputs and PWM/angle outputs of the sweeping servo driver.
interface servo_sweep_pwm_if #(
    parameter int ANGLE_W = 10
);
    logic               enable;
    logic [1:0]         speed;
    logic               servo;
    logic [ANGLE_W-1:0] angle;
    logic               dir;
    logic               frame_tick;
    modport master (output enable, speed, input servo, angle, dir, frame_tick);
    modport slave (input enable, speed, output servo, angle, dir, frame_tick);
endinterface

// File: rtl/servo_sweep_pwm_frame_gen.sv
// pwm_frame_gen: free-running frame counter, end-of-frame tick and glitch-free registered PWM compare.
module pwm_frame_gen import servo_pkg::*; #(
    parameter int PERIOD_CYCLES = 1000000,
    parameter int MIN_PULSE     = 50000,
    parameter int CNT_W         = cnt_w(PERIOD_CYCLES)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_pulse_next,
    output logic             o_servo,
    output logic             o_frame_tick
);
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_pulse;
    logic             r_servo;
    logic             r_tick;
    logic             w_last;

    assign w_last       = (r_cnt == CNT_W'(PERIOD_CYCLES - 1));
    assign o_servo      = r_servo;
    assign o_frame_tick = r_tick;

    // Count the frame, flag its last cycle, and drive the pulse from a width that only changes at the frame edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt   <= '0;
            r_pulse <= CNT_W'(MIN_PULSE);
            r_servo <= 1'b0;
            r_tick  <= 1'b0;
        end else begin
            r_cnt   <= w_last ? '0 : r_cnt + 1'b1;
            r_tick  <= (r_cnt == CNT_W'(PERIOD_CYCLES - 2));
            r_servo <= (r_cnt < r_pulse);
            if (i_load) r_pulse <= i_pulse_next;
        end
    end
endmodule

// File: rtl/servo_sweep_pwm.sv
// servo_sweep_pwm: servo PWM whose pulse tracks a back-and-forth angle sweep; define SERVO_DWELL_EN to hold each endpoint for DWELL_FRAMES frames.
module servo_sweep_pwm import servo_pkg::*; #(
    parameter int PERIOD_CYCLES  = 1000000,
    parameter int MIN_PULSE      = 50000,
    parameter int PULSE_PER_UNIT = 500,
    parameter int ANGLE_MAX      = 100,
    parameter int ANGLE_W        = 10,
    parameter int DWELL_FRAMES   = 4
) (
    input logic              clock,
    input logic              reset,
    servo_sweep_pwm_if.slave bus
);
    localparam int CNT_W = cnt_w(PERIOD_CYCLES);

    state_t             r_state;
    state_t             r_saved;
    state_t             w_run;
    logic [ANGLE_W-1:0] r_angle;
    logic               r_dir;
    logic               w_tick;
    logic [3:0]         w_step;
    logic [ANGLE_W:0]   w_step_x;
    logic [ANGLE_W:0]   w_cur;
    logic [ANGLE_W:0]   w_sum;
    logic [ANGLE_W-1:0] w_up;
    logic [ANGLE_W-1:0] w_dn;
    logic [ANGLE_W-1:0] w_mv;
    logic [ANGLE_W-1:0] w_next;
    logic               w_hit;
    logic               w_hold;
    logic [CNT_W-1:0]   w_pulse_next;

    assign w_step   = speed_step(bus.speed);
    assign w_step_x = (ANGLE_W + 1)'(w_step);
    assign w_cur    = {1'b0, r_angle};
    assign w_sum    = w_cur + w_step_x;
    assign w_up     = (w_sum >= (ANGLE_W + 1)'(ANGLE_MAX)) ? ANGLE_W'(ANGLE_MAX) : w_sum[ANGLE_W-1:0];
    assign w_dn     = (w_cur <= w_step_x) ? '0 : ANGLE_W'(w_cur - w_step_x);
    assign w_mv     = r_dir ? w_dn : w_up;
    assign w_hit    = r_dir ? (w_mv == '0) : (w_mv == ANGLE_W'(ANGLE_MAX));

`ifdef SERVO_DWELL_EN
    localparam int DW_W = $clog2(DWELL_FRAMES + 2);
    logic [DW_W-1:0] r_dwell;
    state_t          w_mode;

    assign w_mode = (r_state == PAUSE) ? r_saved : r_state;
    assign w_hold = (w_mode == DWELL) && (r_dwell != DW_W'(DWELL_FRAMES));
    assign w_run  = w_hit ? DWELL : (r_dir ? DOWN : UP);

    // Count held endpoint frames; the count freezes while paused and clears once the sweep moves again.
    always_ff @(posedge clock) begin
        if (reset) r_dwell <= '0;
        else if (w_tick && bus.enable) r_dwell <= w_hold ? r_dwell + 1'b1 : '0;
    end
`else
    localparam int unused_dwell_frames = DWELL_FRAMES;

    assign w_hold = 1'b0;
    assign w_run  = w_hit ? (r_dir ? UP : DOWN) : (r_dir ? DOWN : UP);
`endif

    assign w_next       = (!bus.enable || w_hold) ? r_angle : w_mv;
    assign w_pulse_next = CNT_W'(MIN_PULSE) + CNT_W'(w_next) * CNT_W'(PULSE_PER_UNIT);
    assign bus.angle    = r_angle;
    assign bus.dir      = r_dir;
    assign bus.frame_tick = w_tick;

    pwm_frame_gen #(
        .PERIOD_CYCLES (PERIOD_CYCLES),
        .MIN_PULSE     (MIN_PULSE),
        .CNT_W         (CNT_W)
    ) u_frame (
        .clock        (clock),
        .reset        (reset),
        .i_load       (w_tick),
        .i_pulse_next (w_pulse_next),
        .o_servo      (bus.servo),
        .o_frame_tick (w_tick)
    );

    // Sweep FSM: at each frame boundary pause, hold an endpoint, or step with clamping and same-update reversal.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= UP;
            r_saved <= UP;
            r_angle <= '0;
            r_dir   <= 1'b0;
        end else if (w_tick) begin
            if (!bus.enable) begin
                r_state <= PAUSE;
                if (r_state != PAUSE) r_saved <= r_state;
            end else if (w_hold) begin
                r_state <= DWELL;
            end else begin
                r_state <= w_run;
                r_angle <= w_mv;
                r_dir   <= r_dir ^ w_hit;
            end
        end
    end
endmodule

// File: tb/tb_servo_sweep_pwm.sv
// tb_servo_sweep_pwm: directed frame-by-frame checks of the sweeping servo driver (default and SERVO_DWELL_EN builds).
module tb_servo_sweep_pwm;
    localparam int AW = 10;
`ifdef SERVO_DWELL_EN
    localparam bit DW = 1'b1;
`else
    localparam bit DW = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail = 0;

    servo_sweep_pwm_if #(.ANGLE_W(AW)) bus ();

    servo_sweep_pwm #(
        .PERIOD_CYCLES  (100),
        .MIN_PULSE      (10),
        .PULSE_PER_UNIT (2),
        .ANGLE_MAX      (20),
        .ANGLE_W        (AW),
        .DWELL_FRAMES   (2)
    ) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic do_reset(input logic en, input logic [1:0] spd);
        @(negedge clk);
        rst = 1'b1;
        bus.enable = en;
        bus.speed = spd;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic measure_frame(input logic en_mid, input logic [1:0] spd_mid, output int hi,
                                 output int ang, output logic d, output int tks, output logic tk_end);
        hi = 0; ang = 0; d = 1'b0; tks = 0; tk_end = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (i == 0) begin
                ang = int'(bus.angle);
                d = bus.dir;
            end
            if (i == 50) begin
                bus.enable = en_mid;
                bus.speed = spd_mid;
            end
            hi += int'(bus.servo);
            tks += int'(bus.frame_tick);
            if (i == 99) tk_end = bus.frame_tick;
        end
    endtask

    task automatic test_reset();
        int hi, ang, tks;
        logic d, te;
        @(negedge clk);
        rst = 1'b1;
        bus.enable = 1'b1;
        bus.speed = 2'b00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tests++; if (bus.servo !== 1'b0) begin n_fail++; $display("FAIL reset_servo got %b exp 0", bus.servo); end
        n_tests++; if (bus.angle !== '0) begin n_fail++; $display("FAIL reset_angle got %0d exp 0", bus.angle); end
        n_tests++; if (bus.dir !== 1'b0) begin n_fail++; $display("FAIL reset_dir got %b exp 0", bus.dir); end
        n_tests++; if (bus.frame_tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick got %b exp 0", bus.frame_tick); end
        @(posedge clk);
        #1 rst = 1'b0;
        measure_frame(1'b1, 2'b00, hi, ang, d, tks, te);
        n_tests++; if (hi != 10) begin n_fail++; $display("FAIL reset_frame0_high got %0d exp 10", hi); end
        n_tests++; if (te !== 1'b1 || tks != 1) begin n_fail++; $display("FAIL reset_frame0_tick got %0d/%b exp 1/1", tks, te); end
    endtask

    task automatic test_sweep_up();
        int hi, ang, tks, ea;
        logic d, te, ed;
        do_reset(1'b1, 2'b00);
        for (int f = 0; f < 22; f++) begin
            measure_frame(1'b1, 2'b00, hi, ang, d, tks, te);
            ea = (f <= 20) ? f : (DW ? 20 : 19);
            ed = (f >= 20);
            n_tests++; if (ang != ea) begin n_fail++; $display("FAIL sweep_angle f%0d got %0d exp %0d", f, ang, ea); end
            n_tests++; if (hi != 10 + 2 * ea) begin n_fail++; $display("FAIL sweep_high f%0d got %0d exp %0d", f, hi, 10 + 2 * ea); end
            n_tests++; if (d !== ed) begin n_fail++; $display("FAIL sweep_dir f%0d got %b exp %b", f, d, ed); end
        end
    endtask

    task automatic test_overshoot();
        int hi, ang, tks, nf;
        int exp_a[14];
        int exp_d[14];
        logic d, te;
        if (DW) begin
            exp_a = '{0, 4, 8, 12, 16, 20, 20, 20, 12, 4, 0, 0, 0, 8};
            exp_d = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 0, 0, 0, 0};
            nf = 14;
        end else begin
            exp_a = '{0, 4, 8, 12, 16, 20, 12, 4, 0, 8, 0, 0, 0, 0};
            exp_d = '{0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0};
            nf = 10;
        end
        do_reset(1'b1, 2'b10);
        for (int f = 0; f < nf; f++) begin
            measure_frame(1'b1, (f < 4) ? 2'b10 : 2'b11, hi, ang, d, tks, te);
            n_tests++; if (ang != exp_a[f]) begin n_fail++; $display("FAIL over_angle f%0d got %0d exp %0d", f, ang, exp_a[f]); end
            n_tests++; if (hi != 10 + 2 * exp_a[f]) begin n_fail++; $display("FAIL over_high f%0d got %0d exp %0d", f, hi, 10 + 2 * exp_a[f]); end
            n_tests++; if (hi > 50) begin n_fail++; $display("FAIL over_high_max f%0d got %0d exp <=50", f, hi); end
            n_tests++; if (int'(d) != exp_d[f]) begin n_fail++; $display("FAIL over_dir f%0d got %b exp %0d", f, d, exp_d[f]); end
        end
    endtask

    task automatic test_pause();
        int hi, ang, tks, ea;
        logic d, te;
        do_reset(1'b1, 2'b00);
        for (int f = 0; f < 13; f++) begin
            measure_frame(!(f >= 7 && f <= 9), 2'b00, hi, ang, d, tks, te);
            ea = (f <= 7) ? f : (f <= 10) ? 7 : f - 3;
            n_tests++; if (ang != ea) begin n_fail++; $display("FAIL pause_angle f%0d got %0d exp %0d", f, ang, ea); end
            n_tests++; if (hi != 10 + 2 * ea) begin n_fail++; $display("FAIL pause_high f%0d got %0d exp %0d", f, hi, 10 + 2 * ea); end
            n_tests++; if (d !== 1'b0) begin n_fail++; $display("FAIL pause_dir f%0d got %b exp 0", f, d); end
        end
    endtask

    task automatic test_reset_mid_frame();
        int hi, ang, tks;
        logic d, te;
        do_reset(1'b1, 2'b11);
        measure_frame(1'b1, 2'b11, hi, ang, d, tks, te);
        measure_frame(1'b1, 2'b11, hi, ang, d, tks, te);
        for (int i = 0; i <= 40; i++) begin
            @(negedge clk);
            if (i == 0) begin
                n_tests++; if (bus.angle !== AW'(16)) begin n_fail++; $display("FAIL midrst_pre_angle got %0d exp 16", bus.angle); end
            end
        end
        n_tests++; if (bus.servo !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_servo got %b exp 1", bus.servo); end
        rst = 1'b1;
        @(negedge clk);
        n_tests++; if (bus.servo !== 1'b0) begin n_fail++; $display("FAIL midrst_servo got %b exp 0", bus.servo); end
        n_tests++; if (bus.angle !== '0) begin n_fail++; $display("FAIL midrst_angle got %0d exp 0", bus.angle); end
        n_tests++; if (bus.dir !== 1'b0) begin n_fail++; $display("FAIL midrst_dir got %b exp 0", bus.dir); end
        @(posedge clk);
        #1 rst = 1'b0;
        measure_frame(1'b1, 2'b11, hi, ang, d, tks, te);
        n_tests++; if (ang != 0) begin n_fail++; $display("FAIL midrst_frame_angle got %0d exp 0", ang); end
        n_tests++; if (hi != 10) begin n_fail++; $display("FAIL midrst_frame_high got %0d exp 10", hi); end
        n_tests++; if (tks != 1 || te !== 1'b1) begin n_fail++; $display("FAIL midrst_tick got %0d/%b exp 1/1", tks, te); end
    endtask

    task automatic test_frame_tick();
        int hi, ang, tks;
        logic d, te;
        for (int f = 0; f < 5; f++) begin
            measure_frame(1'b1, 2'b11, hi, ang, d, tks, te);
            n_tests++; if (tks != 1) begin n_fail++; $display("FAIL tick_count f%0d got %0d exp 1", f, tks); end
            n_tests++; if (te !== 1'b1) begin n_fail++; $display("FAIL tick_last f%0d got %b exp 1", f, te); end
        end
    endtask

    task automatic test_dwell();
        int hi, ang, tks, nf;
        int exp_a[10];
        logic d, te, ed;
        if (DW) begin
            exp_a = '{0, 8, 16, 17, 18, 19, 20, 20, 20, 19};
            nf = 10;
        end else begin
            exp_a = '{0, 8, 16, 17, 18, 19, 20, 19, 18, 0};
            nf = 9;
        end
        do_reset(1'b1, 2'b11);
        for (int f = 0; f < nf; f++) begin
            measure_frame(1'b1, (f < 2) ? 2'b11 : 2'b00, hi, ang, d, tks, te);
            ed = (f >= 6);
            n_tests++; if (ang != exp_a[f]) begin n_fail++; $display("FAIL dwell_angle f%0d got %0d exp %0d", f, ang, exp_a[f]); end
            n_tests++; if (hi != 10 + 2 * exp_a[f]) begin n_fail++; $display("FAIL dwell_high f%0d got %0d exp %0d", f, hi, 10 + 2 * exp_a[f]); end
            n_tests++; if (d !== ed) begin n_fail++; $display("FAIL dwell_dir f%0d got %b exp %b", f, d, ed); end
        end
    endtask

    initial begin
        bus.enable = 1'b0;
        bus.speed = 2'b00;
        test_reset();
        test_sweep_up();
        test_overshoot();
        test_pause();
        test_reset_mid_frame();
        test_frame_tick();
        test_dwell();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
